// File: rtl/counter_bcd_display.sv
// Binary-to-BCD display stage: double-dabble converter plus multiplexed common-anode 7-segment scan.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits on the display only.
module counter_bcd_display #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  bin_in,
  output logic [11:0] bcd_out,
  output logic        busy,
  output logic [2:0]  an,
  output logic [6:0]  seg
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state, state_next;
  logic        start;
  logic [7:0]  shreg;
  logic [11:0] scratch;
  logic [11:0] scratch_adj;
  logic [3:0]  shift_cnt;
  logic [7:0]  last_val;
  logic        force_conv;

  logic [CNT_W-1:0] scan_cnt;
  logic [1:0]       idx, idx_next;
  logic             scan_tick;
  logic [3:0]       digit;
  logic             blank;

  function automatic logic [11:0] add3(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    for (int i = 0; i < 3; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'b1000000;
      4'd1:    glyph = 7'b1111001;
      4'd2:    glyph = 7'b0100100;
      4'd3:    glyph = 7'b0110000;
      4'd4:    glyph = 7'b0011001;
      4'd5:    glyph = 7'b0010010;
      4'd6:    glyph = 7'b0000010;
      4'd7:    glyph = 7'b1111000;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0010000;
      default: glyph = 7'b1111111;
    endcase
  endfunction

  function automatic logic [2:0] enable(input logic [1:0] i);
    case (i)
      2'd0:    enable = 3'b110;
      2'd1:    enable = 3'b101;
      2'd2:    enable = 3'b011;
      default: enable = 3'b111;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    case (state)
      IDLE: begin
        if ((bin_in != last_val) || force_conv) begin
          start      = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT:   if (shift_cnt == 4'd7) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy        = (state != IDLE);
  assign scratch_adj = add3(scratch);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg      <= 8'h00;
      scratch    <= 12'h000;
      shift_cnt  <= 4'd0;
      last_val   <= 8'h00;
      force_conv <= 1'b1;
      bcd_out    <= 12'h000;
    end else if (start) begin
      shreg      <= bin_in;
      last_val   <= bin_in;
      scratch    <= 12'h000;
      shift_cnt  <= 4'd0;
      force_conv <= 1'b0;
    end else if (state == SHIFT) begin
      {scratch, shreg} <= {scratch_adj[10:0], shreg, 1'b0};
      shift_cnt        <= shift_cnt + 4'd1;
    end else if (state == DONE) begin
      bcd_out <= scratch;
    end
  end

  // Scan: an and seg are both derived from idx_next so they switch together.
  assign scan_tick = (scan_cnt == SCAN_LAST);

  always_comb begin
    idx_next = idx;
    if (scan_tick) idx_next = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  end

  always_comb begin
    case (idx_next)
      2'd1:    digit = bcd_out[7:4];
      2'd2:    digit = bcd_out[11:8];
      default: digit = bcd_out[3:0];
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    blank = 1'b0;
    if (idx_next == 2'd2 && bcd_out[11:8] == 4'd0) blank = 1'b1;
    if (idx_next == 2'd1 && bcd_out[11:4] == 8'h00) blank = 1'b1;
  end
`else
  assign blank = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= 2'd0;
      an       <= 3'b110;
      seg      <= 7'b1000000;
    end else begin
      scan_cnt <= scan_tick ? '0 : scan_cnt + 1'b1;
      idx      <= idx_next;
      an       <= enable(idx_next);
      seg      <= blank ? 7'b1111111 : glyph(digit);
    end
  end

endmodule

// File: tb/tb_counter_bcd_display.sv
// Directed self-checking bench for counter_bcd_display (REFRESH_DIV = 4).
module tb_counter_bcd_display;

  logic        clk;
  logic        rst;
  logic [7:0]  bin_in;
  logic [11:0] bcd_out;
  logic        busy;
  logic [2:0]  an;
  logic [6:0]  seg;

  int checks = 0;
  int errors = 0;

  counter_bcd_display #(.REFRESH_DIV(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .bin_in  (bin_in),
    .bcd_out (bcd_out),
    .busy    (busy),
    .an      (an),
    .seg     (seg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge where the next posedge performs the capture.
  task automatic run_conv(input string tag, input logic [11:0] exp);
    @(negedge clk);
    check({tag, "_busy_start"}, busy, 1);
    repeat (8) @(negedge clk);
    check({tag, "_busy_edge8"}, busy, 1);
    @(negedge clk);
    check({tag, "_bcd"}, bcd_out, exp);
    check({tag, "_busy_end"}, busy, 0);
  endtask

  function automatic logic [6:0] blank_or_zero();
`ifdef LEADING_ZERO_BLANK_EN
    return 7'b1111111;
`else
    return 7'b1000000;
`endif
  endfunction

  task automatic check_small(input string tag, input logic [6:0] ones_glyph);
    logic [6:0] exp;
    for (int k = 0; k < 12; k++) begin
      case (an)
        3'b110:  exp = ones_glyph;
        3'b101:  exp = blank_or_zero();
        3'b011:  exp = blank_or_zero();
        default: exp = 7'bxxxxxxx;
      endcase
      check({tag, "_seg"}, seg, exp);
      @(negedge clk);
    end
  endtask

  initial begin
    logic [2:0] prev_an;
    logic       found;
    logic [2:0] exp_an;
    logic [6:0] exp_seg;

    rst    = 1'b0;
    bin_in = 8'd0;

    // Asynchronous reset with no clock edge yet
    #2 rst = 1'b1;
    #1;
    check("rst_an", an, 3'b110);
    check("rst_seg", seg, 7'b1000000);
    check("rst_bcd", bcd_out, 12'h000);
    check("rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    run_conv("post_rst", 12'h000);

    bin_in = 8'd255; run_conv("c255", 12'h255);
    bin_in = 8'd9;   run_conv("c9",   12'h009);
    bin_in = 8'd100; run_conv("c100", 12'h100);
    bin_in = 8'd199; run_conv("c199", 12'h199);

    // Input change three shifts into a conversion
    bin_in = 8'd37;
    @(negedge clk);
    repeat (3) @(negedge clk);
    bin_in = 8'd38;
    repeat (6) @(negedge clk);
    check("mid_bcd37", bcd_out, 12'h037);
    check("mid_busy_gap", busy, 0);
    @(negedge clk);
    check("mid_busy_restart", busy, 1);
    repeat (8) @(negedge clk);
    check("mid_bcd_hold", bcd_out, 12'h037);
    @(negedge clk);
    check("mid_bcd38", bcd_out, 12'h038);

    // Reset pulse during the 4th shift of a 200 conversion
    bin_in = 8'd200;
    @(negedge clk);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rmid_an", an, 3'b110);
    check("rmid_seg", seg, 7'b1000000);
    check("rmid_bcd", bcd_out, 12'h000);
    check("rmid_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    run_conv("rmid_conv", 12'h200);

    // Scan sequence for 128
    bin_in = 8'd128;
    run_conv("c128", 12'h128);
    @(negedge clk);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      prev_an = an;
      @(negedge clk);
      if (prev_an == 3'b011 && an == 3'b110) found = 1'b1;
    end
    check("scan_sync", found, 1);
    for (int k = 0; k < 24; k++) begin
      case ((k % 12) / 4)
        0:       begin exp_an = 3'b110; exp_seg = 7'b0000000; end
        1:       begin exp_an = 3'b101; exp_seg = 7'b0100100; end
        default: begin exp_an = 3'b011; exp_seg = 7'b1111001; end
      endcase
      check("scan_an", an, exp_an);
      check("scan_seg", seg, exp_seg);
      @(negedge clk);
    end

    // Leading digits for small values
    bin_in = 8'd7;
    run_conv("c7", 12'h007);
    @(negedge clk);
    check_small("v7", 7'b1111000);
    bin_in = 8'd0;
    run_conv("c0", 12'h000);
    @(negedge clk);
    check_small("v0", 7'b1000000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_bcd_display.md
Name: counter_bcd_display

Overview:
- Downstream display stage for the 8-bit up/down counter output.
- Converts the unsigned binary value to three BCD digits using a sequential shift-add-3 (double-dabble) engine.
- Time-multiplexes the digits onto a common-anode 7-segment display: segments active-low, digit enables active-low.
- Runs on the fast board clock, not the divided counter clock.
- Because `bin_in` comes from a slower domain, the block re-evaluates its input whenever it is idle.

Parameters:
- REFRESH_DIV, 50000, clock cycles each digit stays enabled before the scan advances. Legal range is 1 or more. The scan counter width is $clog2(REFRESH_DIV), with a minimum of 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- bin_in  input  8  unsigned binary value (counter output). Must be stable relative to `clk` between changes.
- bcd_out  output  12  registered BCD value: {hundreds, tens, ones}, one nibble each.
- busy  output  1  high while a conversion is in progress.
- an  output  3  digit enables, active-low, one-hot. an[0] drives ones, an[2] drives hundreds.
- seg  output  7  segment drive, active-low, bit order {g,f,e,d,c,b,a}.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (ports `clk`, `rst`). All state flops are reset asynchronously by `rst`.
- Reset values:
  - bcd_out = 12'h000, busy = 0.
  - Scan counter = 0, digit index = 0, so an = 3'b110.
  - seg = 7'b1000000 (glyph "0").
  - last_val = 8'h00. force_conv = 1, so one conversion runs after reset.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: if (bin_in != last_val) or force_conv:
    - capture bin_in into the 8-bit shift register and into last_val;
    - clear the 12-bit BCD scratch register and the shift count;
    - clear force_conv;
    - go to SHIFT.
  - SHIFT: one iteration per clock. First, add 3 to every scratch nibble that is >= 5. Then shift {scratch, shiftreg} left by 1. Increment the count. After the 8th shift, go to DONE.
  - DONE: load bcd_out from scratch, return to IDLE.
- busy = 1 in SHIFT and DONE; 0 in IDLE.
- Latency: if bin_in differs on the IDLE capture edge (edge 0), bcd_out updates on edge 9 (8 SHIFT edges followed by the DONE edge). Steady-state throughput is one conversion per 10 clocks.
- bin_in changes during SHIFT or DONE are ignored for the conversion in progress. On return to IDLE, the comparison against last_val triggers a fresh conversion, so the final stable input is always displayed.
- Value range: max input 255 gives 12'h255. Hundreds nibble is never greater than 2. bcd_out never holds a non-BCD nibble.
- Scan:
  - The scan counter runs continuously and is independent of the FSM.
  - When the counter equals REFRESH_DIV-1, it wraps to 0 and the digit index advances 0→1→2→0.
  - The index never takes the value 3. If REFRESH_DIV = 1, the index advances every clock.
  - an and seg are registered, so both change on the same edge as the index. Ghosting between digits is not allowed.
- Decoder: maps a nibble 0–9 to standard glyphs, e.g. 0 = 7'b1000000, 1 = 7'b1111001, 8 = 7'b0000000. Any other nibble (unreachable) maps to 7'b1111111.
- Reset mid-conversion: the FSM aborts to IDLE, the outputs return to their reset values, and a conversion of the current bin_in runs after reset is released.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - hundreds digit blanked (seg = 7'b1111111 while its digit is enabled) when hundreds = 0;
  - tens digit blanked when hundreds = 0 and tens = 0;
  - ones digit never blanked;
  - an still scans all three digits.
- Undefined: all digits always show their glyph, including leading zeros.
- bcd_out is unaffected in both cases.

Test Plan:
- Reset handling: assert rst mid-cycle with no clk edge. Required: an = 110, seg = 1000000, bcd_out = 000 immediately. After release, busy pulses for 9 cycles and bcd_out = 12'h000.
- Single conversion: bin_in 0→255 held. Required: busy rises on the edge after the change, bcd_out = 12'h255 exactly 9 edges after capture, busy = 0 on the following cycle. Repeat with 9→12'h009, 100→12'h100, 199→12'h199.
- Mid-conversion change: bin_in = 37, then 38 three cycles into SHIFT. Required: bcd_out = 12'h037, then a second conversion without intervening stimulus, giving 12'h038.
- Scan sequence: REFRESH_DIV = 4, bin_in = 128. Required: an sequence 110,101,011 repeating, each held exactly 4 clocks. seg = "8","2","1" glyphs respectively (0000000, 0100100, 1111001).
- Leading-zero blanking: with LEADING_ZERO_BLANK_EN defined, bin_in = 7 shows seg = 1111111 on digits 2 and 1 and the "7" glyph (1111000) on digit 0. bin_in = 0 shows "0" on digit 0 only. Without the macro, both show "0" on digits 2 and 1.
- Reset mid-operation: rst pulse during the 4th SHIFT of a 200 conversion. Required: outputs return to reset values, and after release bcd_out = 12'h200.
